reg_cmd_bridge: RTL and testbench

- Initiator side of the 14-bit-address / 16-bit-data register bus that the per-group regfiles respond to.
- Accepts a byte-stream command protocol from the host link (UART/SPI byte layer) and decodes each frame into single-cycle wr_en/rd_en bus transactions.
- Returns read data, ACK or NAK bytes on a byte-stream response channel.
- Sits between the host byte PHY and the regfile address decoder/mux.

---
 rtl/reg_cmd_bridge_pkg.sv | 31 +++
 rtl/reg_cmd_bridge_timeout.sv | 40 ++++
 rtl/reg_cmd_bridge.sv | 170 +++++++++++++++++
 tb/tb_reg_cmd_bridge.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_cmd_bridge_pkg.sv
// Shared widths, command codes and FSM state encoding for the register
// command bridge that turns host byte frames into register bus cycles.
package reg_cmd_bridge_pkg;

    localparam int REG_ADDR_W = 14;
    localparam int REG_DATA_W = 16;

    typedef enum logic [1:0] {
        CMD_NONE = 2'b00,
        CMD_WR   = 2'b01,
        CMD_RD   = 2'b10,
        CMD_BAD  = 2'b11
    } cmd_e;

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        ADDR_LO   = 4'd1,
        DATA_HI   = 4'd2,
        DATA_LO   = 4'd3,
        BUS_WR    = 4'd4,
        BUS_RD    = 4'd5,
        RESP_HI   = 4'd6,
        RESP_LO   = 4'd7,
        RESP_CODE = 4'd8
    } bridge_state_e;

    function automatic logic cmd_is_valid(input logic [1:0] cmd);
        return (cmd == CMD_WR) || (cmd == CMD_RD);
    endfunction

endpackage

// File: rtl/reg_cmd_bridge_timeout.sv
// Inter-byte idle counter; expire flags the cycle in which the idle count
// would reach TIMEOUT_CYCLES. TIMEOUT_CYCLES = 0 disables it.
module reg_cmd_bridge_timeout #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic run,
    output logic expire
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : CNT_W'(0);

    logic [CNT_W-1:0] count_r;

    // Saturating idle-cycle counter
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= CNT_W'(0);
        end else if (clear) begin
            count_r <= CNT_W'(0);
        end else if (run && (count_r != CNT_MAX)) begin
            count_r <= count_r + CNT_W'(1);
        end
    end

    // Expiry decode; the caller gives an accepted byte priority over it
    always_comb begin
        expire = 1'b0;
        if (TIMEOUT_CYCLES > 0) begin
            expire = run && (count_r == CNT_LAST);
        end else begin
            expire = 1'b0;
        end
    end

endmodule

// File: rtl/reg_cmd_bridge.sv
// Host byte-frame decoder driving single-cycle register bus strobes and
// returning read data, ACK or NAK bytes on the response stream.
module reg_cmd_bridge
    import reg_cmd_bridge_pkg::*;
#(
    parameter int         TIMEOUT_CYCLES = 1024,
    parameter logic [7:0] ACK_BYTE       = 8'h5A,
    parameter logic [7:0] NAK_BYTE       = 8'hEE
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic                  wr_en,
    output logic                  rd_en,
    output logic [REG_ADDR_W-1:0] addr,
    output logic [REG_DATA_W-1:0] write_data,
    input  logic [REG_DATA_W-1:0] read_data,
    output logic                  busy,
    output logic                  err_pulse
);

    bridge_state_e state_r;
    logic          is_wr_r;
    logic [5:0]    addr_hi_r;
    logic [7:0]    addr_lo_r;
    logic [7:0]    data_hi_r;
    logic [7:0]    resp_lo_r;
    logic          rx_fire_s;
    logic          tx_fire_s;
    logic          to_run_s;
    logic          to_clear_s;
    logic          to_expire_s;

    // Handshake and timeout control decoded from the current state
    always_comb begin
        rx_fire_s  = rx_valid && rx_ready;
        tx_fire_s  = tx_valid && tx_ready;
        to_run_s   = (state_r == ADDR_LO) || (state_r == DATA_HI) || (state_r == DATA_LO);
        to_clear_s = rx_fire_s || (state_r == IDLE);
    end

    reg_cmd_bridge_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .clear  (to_clear_s),
        .run    (to_run_s),
        .expire (to_expire_s)
    );

    // Frame FSM; every output is set on the transition into the state it belongs to
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            is_wr_r    <= 1'b0;
            addr_hi_r  <= 6'd0;
            addr_lo_r  <= 8'd0;
            data_hi_r  <= 8'd0;
            resp_lo_r  <= 8'd0;
            rx_ready   <= 1'b0;
            tx_data    <= 8'd0;
            tx_valid   <= 1'b0;
            wr_en      <= 1'b0;
            rd_en      <= 1'b0;
            addr       <= 14'd0;
            write_data <= 16'd0;
            busy       <= 1'b0;
            err_pulse  <= 1'b0;
        end else begin
            wr_en     <= 1'b0;
            rd_en     <= 1'b0;
            err_pulse <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (rx_fire_s && cmd_is_valid(rx_data[7:6])) begin
                        is_wr_r   <= (rx_data[7:6] == CMD_WR);
                        addr_hi_r <= rx_data[5:0];
                        busy      <= 1'b1;
                        state_r   <= ADDR_LO;
                    end else if (rx_fire_s) begin
                        tx_data   <= NAK_BYTE;
                        tx_valid  <= 1'b1;
                        rx_ready  <= 1'b0;
                        busy      <= 1'b1;
                        err_pulse <= 1'b1;
                        state_r   <= RESP_CODE;
                    end else begin
                        rx_ready  <= 1'b1;
                    end
                end
                ADDR_LO: begin
                    if (rx_fire_s && is_wr_r) begin
                        addr_lo_r <= rx_data;
                        state_r   <= DATA_HI;
                    end else if (rx_fire_s) begin
                        addr      <= {addr_hi_r, rx_data};
                        rd_en     <= 1'b1;
                        rx_ready  <= 1'b0;
                        state_r   <= BUS_RD;
                    end else if (to_expire_s) begin
                        err_pulse <= 1'b1;
                        busy      <= 1'b0;
                        state_r   <= IDLE;
                    end
                end
                DATA_HI: begin
                    if (rx_fire_s) begin
                        data_hi_r <= rx_data;
                        state_r   <= DATA_LO;
                    end else if (to_expire_s) begin
                        err_pulse <= 1'b1;
                        busy      <= 1'b0;
                        state_r   <= IDLE;
                    end
                end
                DATA_LO: begin
                    if (rx_fire_s) begin
                        addr       <= {addr_hi_r, addr_lo_r};
                        write_data <= {data_hi_r, rx_data};
                        wr_en      <= 1'b1;
                        rx_ready   <= 1'b0;
                        state_r    <= BUS_WR;
                    end else if (to_expire_s) begin
                        err_pulse  <= 1'b1;
                        busy       <= 1'b0;
                        state_r    <= IDLE;
                    end
                end
                BUS_WR: begin
                    tx_data  <= ACK_BYTE;
                    tx_valid <= 1'b1;
                    state_r  <= RESP_CODE;
                end
                BUS_RD: begin
                    tx_data   <= read_data[15:8];
                    resp_lo_r <= read_data[7:0];
                    tx_valid  <= 1'b1;
                    state_r   <= RESP_HI;
                end
                RESP_HI: begin
                    if (tx_fire_s) begin
                        tx_data <= resp_lo_r;
                        state_r <= RESP_LO;
                    end
                end
                RESP_LO, RESP_CODE: begin
                    if (tx_fire_s) begin
                        tx_valid <= 1'b0;
                        busy     <= 1'b0;
                        rx_ready <= 1'b1;
                        state_r  <= IDLE;
                    end
                end
                default: begin
                    tx_valid <= 1'b0;
                    rx_ready <= 1'b0;
                    busy     <= 1'b0;
                    state_r  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_cmd_bridge.sv
// Scoreboard bench for reg_cmd_bridge: frames are modelled as whole
// transactions, and a negedge monitor checks strobes, response bytes and errors.
module tb_reg_cmd_bridge;

    localparam int TO = 16;

    typedef struct packed {
        logic        is_wr;
        logic [13:0] addr;
        logic [15:0] data;
    } bus_t;

    logic        clk;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        wr_en;
    logic        rd_en;
    logic [13:0] addr;
    logic [15:0] write_data;
    logic [15:0] read_data;
    logic        busy;
    logic        err_pulse;

    int   n_pass;
    int   n_total;
    int   exp_err_n;
    int   tx_mode;
    bus_t exp_bus_q[$];
    logic [7:0] exp_tx_q[$];
    bus_t mon_e;

    reg_cmd_bridge #(
        .TIMEOUT_CYCLES (TO),
        .ACK_BYTE       (8'h5A),
        .NAK_BYTE       (8'hEE)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .wr_en      (wr_en),
        .rd_en      (rd_en),
        .addr       (addr),
        .write_data (write_data),
        .read_data  (read_data),
        .busy       (busy),
        .err_pulse  (err_pulse)
    );

    // Regfile stand-in: fixed contents per address
    function automatic logic [15:0] rd_model(input logic [13:0] a);
        if (a == 14'h0041) return 16'h1234;
        else return {a[7:0] ^ 8'h3C, 2'b10, a[13:8]};
    endfunction

    assign read_data = rd_model(addr);

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, actual time %0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual %0h required %0h", name, act, exp);
    endtask

    task automatic fail_evt(input string name, input logic [63:0] act);
        n_total++;
        $display("FAIL %s: actual %0h required no such event", name, act);
    endtask

    function automatic logic [63:0] outs();
        return {20'd0, rx_ready, tx_valid, tx_data, wr_en, rd_en, addr, write_data, busy, err_pulse};
    endfunction

    // Reference model: what a whole frame must produce
    task automatic push_expect(input logic [1:0] cmd, input logic [13:0] a, input logic [15:0] d);
        bus_t e;
        logic [15:0] rv;
        if (cmd == 2'b01) begin
            e.is_wr = 1'b1; e.addr = a; e.data = d;
            exp_bus_q.push_back(e);
            exp_tx_q.push_back(8'h5A);
        end else if (cmd == 2'b10) begin
            rv = rd_model(a);
            e.is_wr = 1'b0; e.addr = a; e.data = 16'h0000;
            exp_bus_q.push_back(e);
            exp_tx_q.push_back(rv[15:8]);
            exp_tx_q.push_back(rv[7:0]);
        end else begin
            exp_err_n++;
            exp_tx_q.push_back(8'hEE);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        bit done;
        done = 1'b0;
        repeat (gap) begin
            @(posedge clk); #1;
        end
        rx_data  = b;
        rx_valid = 1'b1;
        for (int i = 0; i < 500 && !done; i++) begin
            @(negedge clk);
            if (rx_ready) begin
                @(posedge clk); #1;
                done = 1'b1;
            end
        end
        rx_valid = 1'b0;
        if (!done) fail_evt("rx_accept_timeout", 64'(b));
    endtask

    task automatic issue_frame(input logic [1:0] cmd, input logic [13:0] a, input logic [15:0] d);
        push_expect(cmd, a, d);
        send_byte({cmd, a[13:8]}, $urandom_range(0, 3));
        if (cmd == 2'b01 || cmd == 2'b10) send_byte(a[7:0], $urandom_range(0, 4));
        if (cmd == 2'b01) begin
            send_byte(d[15:8], $urandom_range(0, 4));
            send_byte(d[7:0], $urandom_range(0, 4));
        end
    endtask

    task automatic wait_idle(input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 1000 && !ok; i++) begin
            @(negedge clk);
            if (exp_bus_q.size() == 0 && exp_tx_q.size() == 0 && exp_err_n == 0 && !busy) ok = 1'b1;
        end
        @(posedge clk); #1;
        if (!ok) fail_evt({tag, "_drain_timeout"}, 64'(exp_tx_q.size()));
    endtask

    task automatic wait_tx_valid(input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (tx_valid) ok = 1'b1;
        end
        if (!ok) fail_evt({tag, "_tx_valid_timeout"}, 64'(tx_valid));
    endtask

    // tx_ready driver: 0 hold low, 1 random, 2 hold high, 3 manual
    initial begin
        tx_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (tx_mode)
                0: tx_ready = 1'b0;
                1: tx_ready = ($urandom_range(0, 3) != 0);
                2: tx_ready = 1'b1;
                default: ;
            endcase
        end
    end

    // Monitor: every DUT event must match the head of its expectation queue
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (wr_en && rd_en) fail_evt("strobe_both", 64'({wr_en, rd_en}));
                if (wr_en || rd_en) begin
                    if (exp_bus_q.size() == 0) begin
                        fail_evt("strobe_stray", 64'({wr_en, rd_en, addr}));
                    end else begin
                        mon_e = exp_bus_q.pop_front();
                        check("strobe_kind", 64'({wr_en, rd_en}), 64'({mon_e.is_wr, ~mon_e.is_wr}));
                        check("strobe_addr", 64'(addr), 64'(mon_e.addr));
                        if (mon_e.is_wr) check("strobe_wdata", 64'(write_data), 64'(mon_e.data));
                    end
                end
                if (tx_valid && tx_ready) begin
                    if (exp_tx_q.size() == 0) fail_evt("tx_stray", 64'(tx_data));
                    else check("tx_byte", 64'(tx_data), 64'(exp_tx_q.pop_front()));
                end
                if (err_pulse) begin
                    if (exp_err_n == 0) fail_evt("err_stray", 64'(err_pulse));
                    else exp_err_n--;
                end
            end
        end
    end

    initial begin
        logic [13:0] a;
        logic [15:0] rv;
        int bad;
        n_pass    = 0;
        n_total   = 0;
        exp_err_n = 0;
        tx_mode   = 1;
        rst       = 1'b1;
        rx_valid  = 1'b0;
        rx_data   = 8'h00;
        repeat (3) @(posedge clk); #1;
        check("reset_outputs", outs(), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("rx_ready_after_reset", 64'(rx_ready), 64'd1);

        issue_frame(2'b01, 14'h0002, 16'hABCD);
        wait_idle("write");
        check("write_busy_after", 64'(busy), 64'd0);
        check("write_addr_hold", 64'(addr), 64'h0002);
        check("write_data_hold", 64'(write_data), 64'hABCD);

        issue_frame(2'b10, 14'h0041, 16'h0000);
        wait_idle("read");
        check("read_addr_hold", 64'(addr), 64'h0041);
        check("read_keeps_wdata", 64'(write_data), 64'hABCD);

        issue_frame(2'b11, 14'h0000, 16'h0000);
        issue_frame(2'b10, 14'h0123, 16'h0000);
        wait_idle("invalid");
        issue_frame(2'b00, 14'h3FFF, 16'h0000);
        wait_idle("invalid00");

        exp_err_n++;
        send_byte(8'h40, 0);
        repeat (TO - 1) @(posedge clk);
        #1;
        check("timeout_not_early", 64'({busy, err_pulse}), 64'b10);
        @(posedge clk); #1;
        check("timeout_fires", 64'({busy, err_pulse, rx_ready}), 64'b011);
        wait_idle("timeout");

        push_expect(2'b01, 14'h0077, 16'h1357);
        send_byte(8'h40, 0);
        repeat (TO - 1) @(posedge clk);
        #1;
        rx_data  = 8'h77;
        rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
        check("boundary_byte_wins", 64'({busy, err_pulse}), 64'b10);
        send_byte(8'h13, 0);
        send_byte(8'h57, 0);
        wait_idle("boundary");

        for (int i = 0; i < 40; i++) begin
            issue_frame(2'($urandom_range(0, 3)), 14'($urandom), 16'($urandom));
        end
        wait_idle("random");

        tx_mode = 0;
        a  = 14'h2A5C;
        rv = rd_model(a);
        issue_frame(2'b10, a, 16'h0000);
        wait_tx_valid("backpressure");
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (!(tx_valid && tx_data == rv[15:8] && !rx_ready)) bad++;
        end
        check("backpressure_hold", 64'(bad), 64'd0);
        tx_mode = 1;
        wait_idle("backpressure");

        tx_mode = 0;
        repeat (2) @(posedge clk);
        #1;
        tx_mode = 3;
        a  = 14'h1F0E;
        rv = rd_model(a);
        issue_frame(2'b10, a, 16'h0000);
        wait_tx_valid("reset");
        @(posedge clk); #1;
        tx_ready = 1'b1;
        @(posedge clk); #1;
        tx_ready = 1'b0;
        check("resp_lo_presented", 64'({tx_valid, tx_data}), 64'({1'b1, rv[7:0]}));
        rst = 1'b1;
        exp_tx_q.delete();
        @(posedge clk); #1;
        check("reset_mid_resp", outs(), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst     = 1'b0;
        tx_mode = 2;
        repeat (30) @(posedge clk);
        #1;
        check("post_reset_quiet", 64'({busy, tx_valid}), 64'b00);

        check("final_bus_q_empty", 64'(exp_bus_q.size()), 64'd0);
        check("final_tx_q_empty", 64'(exp_tx_q.size()), 64'd0);
        check("final_err_balance", 64'(exp_err_n), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
